tictactoe_move_ctrl: RTL and testbench

Turn controller for the tic-tac-toe datapath, directly upstream of the board position register. It accepts the player's move request, validates it against the current board, and produces the one-hot `p_enable`, `c_enable` and `wrong_move` strobes the position register consumes. It alternates player and computer turns, and stops when the downstream win detector reports a result or the board is full.

---
 rtl/tictactoe_move_ctrl.sv | 119 +++++++++++
 tb/tb_tictactoe_move_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tictactoe_move_ctrl.sv
// Turn controller for tic-tac-toe: validates player moves, picks the computer's
// reply from a fixed priority order, and emits one-cycle write strobes for the board.
module tictactoe_move_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        play,
  input  logic [3:0]  player_pos,
  input  logic [1:0]  pos1,
  input  logic [1:0]  pos2,
  input  logic [1:0]  pos3,
  input  logic [1:0]  pos4,
  input  logic [1:0]  pos5,
  input  logic [1:0]  pos6,
  input  logic [1:0]  pos7,
  input  logic [1:0]  pos8,
  input  logic [1:0]  pos9,
  input  logic        game_done,
  output logic [15:0] p_enable,
  output logic [15:0] c_enable,
  output logic        wrong_move,
  output logic        game_over,
  output logic [3:0]  turn_count
);

  typedef enum logic [2:0] {IDLE, P_PLACE, P_CHECK, C_PLACE, C_CHECK, DONE} state_t;

  state_t      state, state_nxt;
  logic        play_q;
  logic [8:0]  empty;
  logic [15:0] empty16;
  logic        full, req, pos_ok;
  logic [15:0] p_nxt, c_nxt;
  logic        wrong_nxt;
  logic [3:0]  count_nxt;
  logic [3:0]  count_inc;

  // Computer preference: centre, corners, then edges.
  function automatic logic [15:0] pick_cell(input logic [8:0] e);
    pick_cell = 16'h0000;
    if      (e[4]) pick_cell = 16'h0010;
    else if (e[0]) pick_cell = 16'h0001;
    else if (e[2]) pick_cell = 16'h0004;
    else if (e[6]) pick_cell = 16'h0040;
    else if (e[8]) pick_cell = 16'h0100;
    else if (e[1]) pick_cell = 16'h0002;
    else if (e[3]) pick_cell = 16'h0008;
    else if (e[5]) pick_cell = 16'h0020;
    else if (e[7]) pick_cell = 16'h0080;
  endfunction

  assign empty = {pos9 == 2'b00, pos8 == 2'b00, pos7 == 2'b00, pos6 == 2'b00, pos5 == 2'b00,
                  pos4 == 2'b00, pos3 == 2'b00, pos2 == 2'b00, pos1 == 2'b00};
  assign empty16   = {7'b0, empty};
  assign full      = ~|empty;
  assign req       = play & ~play_q;
  // Positions 10..15 index the zero-padded upper bits, so they read as occupied.
  assign pos_ok    = (player_pos != 4'd0) && empty16[player_pos - 4'd1];
  assign count_inc = (turn_count == 4'd9) ? 4'd9 : turn_count + 4'd1;

  always_comb begin
    state_nxt = state;
    p_nxt     = 16'h0000;
    c_nxt     = 16'h0000;
    wrong_nxt = 1'b0;
    count_nxt = turn_count;
    case (state)
      IDLE: begin
        if (req) begin
          if (pos_ok) begin
            p_nxt     = 16'h0001 << (player_pos - 4'd1);
            state_nxt = P_PLACE;
          end else begin
            wrong_nxt = 1'b1;
          end
        end
      end
      P_PLACE: begin
        count_nxt = count_inc;
        state_nxt = P_CHECK;
      end
      P_CHECK: begin
        if (game_done || full) begin
          state_nxt = DONE;
        end else begin
          c_nxt     = pick_cell(empty);
          state_nxt = C_PLACE;
        end
      end
      C_PLACE: begin
        count_nxt = count_inc;
        state_nxt = C_CHECK;
      end
      C_CHECK: state_nxt = (game_done || full) ? DONE : IDLE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      play_q     <= 1'b1;
      p_enable   <= 16'h0000;
      c_enable   <= 16'h0000;
      wrong_move <= 1'b0;
      game_over  <= 1'b0;
      turn_count <= 4'd0;
    end else begin
      state      <= state_nxt;
      play_q     <= play;
      p_enable   <= p_nxt;
      c_enable   <= c_nxt;
      wrong_move <= wrong_nxt;
      game_over  <= (state_nxt == DONE);
      turn_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_tictactoe_move_ctrl.sv
// Directed bench for tictactoe_move_ctrl with a behavioural board register
// that applies the DUT's write strobes.
module tb_tictactoe_move_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        play = 1'b0;
  logic [3:0]  player_pos = 4'd0;
  logic        game_done = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  board [9];
  logic [15:0] p_enable, c_enable;
  logic        wrong_move, game_over;
  logic [3:0]  turn_count;
  int          total = 0;
  int          bad = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    for (int k = 0; k < 9; k++) begin
      if (clr) board[k] <= 2'b00;
      else if (p_enable[k]) board[k] <= 2'b01;
      else if (c_enable[k]) board[k] <= 2'b10;
    end
  end

  tictactoe_move_ctrl dut (
    .clock(clock), .reset(reset), .play(play), .player_pos(player_pos),
    .pos1(board[0]), .pos2(board[1]), .pos3(board[2]), .pos4(board[3]), .pos5(board[4]),
    .pos6(board[5]), .pos7(board[6]), .pos8(board[7]), .pos9(board[8]),
    .game_done(game_done), .p_enable(p_enable), .c_enable(c_enable),
    .wrong_move(wrong_move), .game_over(game_over), .turn_count(turn_count)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; play = 1'b0;
    tick;
    reset = 1'b0;
    clr = 1'b1;
    tick;
    clr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; play = 1'b0; clr = 1'b1;
    tick;
    reset = 1'b0; clr = 1'b0;
    total++; if (p_enable !== 16'h0000) begin bad++; $display("FAIL reset_p got=%h want=0000", p_enable); end
    total++; if (c_enable !== 16'h0000) begin bad++; $display("FAIL reset_c got=%h want=0000", c_enable); end
    total++; if (wrong_move !== 1'b0) begin bad++; $display("FAIL reset_wrong got=%b want=0", wrong_move); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_over got=%b want=0", game_over); end
    total++; if (turn_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", turn_count); end
    tick;
  endtask

  task automatic do_turn(input logic [3:0] pos, input logic [15:0] exp_c, input string tag);
    logic [15:0] exp_p;
    exp_p = 16'h0001 << (pos - 4'd1);
    player_pos = pos; play = 1'b1;
    tick;
    total++; if (p_enable !== exp_p) begin bad++; $display("FAIL %s_p got=%h want=%h", tag, p_enable, exp_p); end
    total++; if (c_enable !== 16'h0000) begin bad++; $display("FAIL %s_c_early got=%h want=0000", tag, c_enable); end
    play = 1'b0;
    tick;
    total++; if (p_enable !== 16'h0000) begin bad++; $display("FAIL %s_p_len got=%h want=0000", tag, p_enable); end
    tick;
    total++; if (c_enable !== exp_c) begin bad++; $display("FAIL %s_c got=%h want=%h", tag, c_enable, exp_c); end
    tick;
    total++; if (c_enable !== 16'h0000) begin bad++; $display("FAIL %s_c_len got=%h want=0000", tag, c_enable); end
    tick;
  endtask

  task automatic test_opening;
    do_turn(4'd1, 16'h0010, "open");
    total++; if (turn_count !== 4'd2) begin bad++; $display("FAIL open_count got=%0d want=2", turn_count); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL open_over got=%b want=0", game_over); end
  endtask

  task automatic test_illegal;
    logic [3:0] bad_pos [3];
    bad_pos[0] = 4'd5; bad_pos[1] = 4'd0; bad_pos[2] = 4'd12;
    for (int i = 0; i < 3; i++) begin
      player_pos = bad_pos[i]; play = 1'b1;
      tick;
      total++; if (wrong_move !== 1'b1) begin bad++; $display("FAIL illegal_wrong pos=%0d got=%b want=1", bad_pos[i], wrong_move); end
      total++; if ((p_enable | c_enable) !== 16'h0000) begin bad++; $display("FAIL illegal_en pos=%0d got=%h want=0000", bad_pos[i], p_enable | c_enable); end
      play = 1'b0;
      tick;
      total++; if (wrong_move !== 1'b0) begin bad++; $display("FAIL illegal_pulse pos=%0d got=%b want=0", bad_pos[i], wrong_move); end
    end
    total++; if (turn_count !== 4'd2) begin bad++; $display("FAIL illegal_count got=%0d want=2", turn_count); end
  endtask

  task automatic test_held_button;
    int pcnt = 0, ccnt = 0;
    logic [15:0] pval = 16'h0, cval = 16'h0;
    player_pos = 4'd2; play = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (p_enable != 16'h0) begin pcnt++; pval = p_enable; end
      if (c_enable != 16'h0) begin ccnt++; cval = c_enable; end
    end
    play = 1'b0;
    tick;
    total++; if (pcnt != 1) begin bad++; $display("FAIL held_pcount got=%0d want=1", pcnt); end
    total++; if (pval !== 16'h0002) begin bad++; $display("FAIL held_pval got=%h want=0002", pval); end
    total++; if (ccnt != 1) begin bad++; $display("FAIL held_ccount got=%0d want=1", ccnt); end
    total++; if (cval !== 16'h0004) begin bad++; $display("FAIL held_cval got=%h want=0004", cval); end
    total++; if (turn_count !== 4'd4) begin bad++; $display("FAIL held_count got=%0d want=4", turn_count); end
  endtask

  task automatic test_win_stop;
    player_pos = 4'd4; play = 1'b1;
    tick;
    total++; if (p_enable !== 16'h0008) begin bad++; $display("FAIL win_p got=%h want=0008", p_enable); end
    play = 1'b0;
    tick;
    game_done = 1'b1;
    tick;
    total++; if (c_enable !== 16'h0000) begin bad++; $display("FAIL win_c got=%h want=0000", c_enable); end
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL win_over got=%b want=1", game_over); end
    game_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      player_pos = (i % 2 == 0) ? 4'd6 : 4'd0; play = 1'b1;
      tick;
      total++; if ((p_enable | c_enable) !== 16'h0000 || wrong_move !== 1'b0) begin
        bad++; $display("FAIL done_ignore i=%0d en=%h wrong=%b want en=0000 wrong=0", i, p_enable | c_enable, wrong_move);
      end
      play = 1'b0;
      tick;
      total++; if (c_enable !== 16'h0000) begin bad++; $display("FAIL done_c i=%0d got=%h want=0000", i, c_enable); end
    end
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL done_hold got=%b want=1", game_over); end
    total++; if (turn_count !== 4'd5) begin bad++; $display("FAIL win_count got=%0d want=5", turn_count); end
  endtask

  task automatic test_full_board;
    do_reset;
    do_turn(4'd2, 16'h0010, "full1");
    do_turn(4'd4, 16'h0001, "full2");
    do_turn(4'd6, 16'h0004, "full3");
    do_turn(4'd8, 16'h0040, "full4");
    player_pos = 4'd9; play = 1'b1;
    tick;
    total++; if (p_enable !== 16'h0100) begin bad++; $display("FAIL full_last_p got=%h want=0100", p_enable); end
    play = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++; if (c_enable !== 16'h0000) begin bad++; $display("FAIL full_c i=%0d got=%h want=0000", i, c_enable); end
    end
    total++; if (turn_count !== 4'd9) begin bad++; $display("FAIL full_count got=%0d want=9", turn_count); end
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL full_over got=%b want=1", game_over); end
  endtask

  task automatic test_reset_mid_turn;
    do_reset;
    player_pos = 4'd1; play = 1'b1;
    tick;
    tick;
    tick;
    total++; if (c_enable !== 16'h0010) begin bad++; $display("FAIL mid_c_before got=%h want=0010", c_enable); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++; if (c_enable !== 16'h0000) begin bad++; $display("FAIL mid_c got=%h want=0000", c_enable); end
    total++; if (turn_count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", turn_count); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL mid_over got=%b want=0", game_over); end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (p_enable !== 16'h0000) begin bad++; $display("FAIL mid_held i=%0d got=%h want=0000", i, p_enable); end
    end
    play = 1'b0;
    tick;
    do_turn(4'd1, 16'h0010, "mid_after");
    total++; if (turn_count !== 4'd2) begin bad++; $display("FAIL mid_after_count got=%0d want=2", turn_count); end
  endtask

  initial begin
    test_reset;
    test_opening;
    test_illegal;
    test_held_button;
    test_win_stop;
    test_full_board;
    test_reset_mid_turn;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
